// File: rtl/audio_transport_ctrl.sv
// audio_transport_ctrl: record/play/pause/stop sequencer between the audio stream block and sample memory.
// Define LOOP_PLAY_EN to restart playback from address 0 at the end of the clip.
module audio_transport_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int MAX_ADDR = 2**ADDR_W-1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rec,
  input  logic              i_play,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic              o_record_audio_ready,
  input  logic [31:0]       i_record_audio_data,
  input  logic              i_record_audio_valid,
  output logic              o_play_audio_valid,
  output logic [31:0]       o_play_audio_data,
  input  logic              i_play_audio_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_we,
  output logic              o_mem_re,
  input  logic [31:0]       i_mem_rdata,
  input  logic              i_mem_ack,
  output logic [ADDR_W:0]   o_rec_len,
  output logic [2:0]        o_state,
  output logic              o_busy
);
  localparam logic [2:0] IDLE = 3'd0, REC_WAIT = 3'd1, REC_WR = 3'd2, PLAY_RD = 3'd3, PLAY_OUT = 3'd4, PAUSE = 3'd5;
`ifdef LOOP_PLAY_EN
  localparam logic LOOP = 1'b1;
`else
  localparam logic LOOP = 1'b0;
`endif
  logic [2:0] state, nxt;
  logic [ADDR_W-1:0] addr;
  logic pause_pending, stop_pending, play_dir;
  logic last_rec, clip_end, pend, stp;
  assign last_rec = addr == ADDR_W'(MAX_ADDR);
  assign clip_end = ({1'b0, addr} + (ADDR_W+1)'(1)) == o_rec_len;
  assign pend = pause_pending | i_pause;
  assign stp = stop_pending | i_stop;
  assign o_mem_addr = addr;
  assign o_state = state;
  assign o_busy = state != IDLE;
  // memory requests always run to their ack; stop and pause act only at sample boundaries
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:     nxt = i_rec ? REC_WAIT : (i_play && o_rec_len != '0) ? PLAY_RD : IDLE;
      REC_WAIT: nxt = i_stop ? IDLE : i_record_audio_valid ? REC_WR : i_pause ? PAUSE : REC_WAIT;
      REC_WR:   nxt = !i_mem_ack ? REC_WR : (stp || last_rec) ? IDLE : pend ? PAUSE : REC_WAIT;
      PLAY_RD:  nxt = !i_mem_ack ? PLAY_RD : stp ? IDLE : PLAY_OUT;
      PLAY_OUT: nxt = i_stop ? IDLE : !i_play_audio_ready ? PLAY_OUT : (clip_end && !LOOP) ? IDLE : pend ? PAUSE : PLAY_RD;
      PAUSE:    nxt = i_stop ? IDLE : i_pause ? (play_dir ? PLAY_RD : REC_WAIT) : PAUSE;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      addr <= '0;
      o_rec_len <= '0;
      pause_pending <= 1'b0;
      stop_pending <= 1'b0;
      play_dir <= 1'b0;
      o_mem_wdata <= '0;
      o_play_audio_data <= '0;
      o_record_audio_ready <= 1'b0;
      o_mem_we <= 1'b0;
      o_mem_re <= 1'b0;
      o_play_audio_valid <= 1'b0;
    end else begin
      state <= nxt;
      o_record_audio_ready <= nxt == REC_WAIT;
      o_mem_we <= nxt == REC_WR;
      o_mem_re <= nxt == PLAY_RD;
      o_play_audio_valid <= nxt == PLAY_OUT;
      pause_pending <= (nxt == PAUSE || nxt == IDLE) ? 1'b0 : (i_pause && state inside {REC_WAIT, REC_WR, PLAY_RD, PLAY_OUT}) ? 1'b1 : pause_pending;
      stop_pending <= nxt == IDLE ? 1'b0 : (i_stop && state inside {REC_WR, PLAY_RD}) ? 1'b1 : stop_pending;
      if (state == IDLE && i_rec) begin
        addr <= '0;
        o_rec_len <= '0;
        play_dir <= 1'b0;
      end else if (state == IDLE && nxt == PLAY_RD) begin
        addr <= '0;
        play_dir <= 1'b1;
      end
      if (state == REC_WAIT && i_record_audio_valid && !i_stop) o_mem_wdata <= i_record_audio_data;
      if (state == REC_WR && i_mem_ack) begin
        o_rec_len <= {1'b0, addr} + (ADDR_W+1)'(1);
        if (nxt != IDLE) addr <= addr + ADDR_W'(1);
      end
      if (state == PLAY_RD && i_mem_ack) o_play_audio_data <= i_mem_rdata;
      if (state == PLAY_OUT && i_play_audio_ready && !i_stop) addr <= clip_end ? '0 : addr + ADDR_W'(1);
    end
  end
endmodule

// File: tb/tb_audio_transport_ctrl.sv
// tb_audio_transport_ctrl: scoreboard bench; memory/stream models feed the DUT, a monitor checks bus events.
module tb_audio_transport_ctrl;
  localparam int AW = 3;
  logic i_clk = 0, i_rst = 1;
  logic i_rec = 0, i_play = 0, i_pause = 0, i_stop = 0;
  logic o_record_audio_ready, i_record_audio_valid = 0;
  logic [31:0] i_record_audio_data = '0;
  logic o_play_audio_valid, i_play_audio_ready = 0;
  logic [31:0] o_play_audio_data;
  logic [AW-1:0] o_mem_addr;
  logic [31:0] o_mem_wdata, i_mem_rdata = '0;
  logic o_mem_we, o_mem_re, i_mem_ack = 0;
  logic [AW:0] o_rec_len;
  logic [2:0] o_state;
  logic o_busy;
  always #5 i_clk = ~i_clk;
  audio_transport_ctrl #(.ADDR_W(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rec(i_rec), .i_play(i_play), .i_pause(i_pause), .i_stop(i_stop),
    .o_record_audio_ready(o_record_audio_ready), .i_record_audio_data(i_record_audio_data),
    .i_record_audio_valid(i_record_audio_valid), .o_play_audio_valid(o_play_audio_valid),
    .o_play_audio_data(o_play_audio_data), .i_play_audio_ready(i_play_audio_ready),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_we(o_mem_we), .o_mem_re(o_mem_re),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack), .o_rec_len(o_rec_len), .o_state(o_state), .o_busy(o_busy)
  );
  typedef struct {byte k; int a; logic [31:0] d;} ev_t;
  ev_t exp_q[$];
  logic [31:0] src_q[$];
  logic [31:0] mem [8];
  logic [31:0] hold_d;
  logic pwe = 0, pre = 0, pv = 0;
  int n_cmp = 0, n_bad = 0, ack_dly = 2, snk_dly = 2;
  logic [31:0] rd [4] = '{32'h11112222, 32'h22223333, 32'h33334444, 32'h44445555};
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic push(byte k, int a, logic [31:0] d);
    ev_t e;
    e.k = k; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask
  task automatic seen(byte k, int a, logic [31:0] d);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected event: got %c@%0d %h want none", k, a, d);
    end else begin
      e = exp_q.pop_front();
      if (e.k != k || e.a != a || e.d !== d) begin
        n_bad++;
        $display("FAIL event: got %c@%0d %h want %c@%0d %h", k, a, d, e.k, e.a, e.d);
      end
    end
  endtask
  // c: 0 rec, 1 play, 2 pause, 3 stop
  task automatic pulse(int c);
    {i_rec, i_play, i_pause, i_stop} = 4'b1000 >> c;
    @(negedge i_clk);
    {i_rec, i_play, i_pause, i_stop} = 4'b0000;
  endtask
  task automatic wait_st(logic [2:0] s, int lim, string nm);
    int i = 0;
    while (o_state !== s && i < lim) begin
      @(negedge i_clk);
      i++;
    end
    chk(nm, 32'(o_state), 32'(s));
  endtask
  task automatic drain(int lim, string nm);
    int i = 0;
    while (exp_q.size() > 0 && i < lim) begin
      @(negedge i_clk);
      i++;
    end
    chk(nm, 32'(exp_q.size()), 32'd0);
  endtask
  initial forever begin
    @(negedge i_clk);
    if (o_mem_we && !pwe) seen("W", int'(o_mem_addr), o_mem_wdata);
    if (o_mem_re && !pre) seen("R", int'(o_mem_addr), 32'd0);
    if (o_play_audio_valid && !pv) seen("P", 0, o_play_audio_data);
    pwe = o_mem_we; pre = o_mem_re; pv = o_play_audio_valid;
  end
  initial forever begin
    @(negedge i_clk);
    if ((o_mem_we || o_mem_re) && !i_rst) begin
      repeat (ack_dly - 1) @(negedge i_clk);
      if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
      else i_mem_rdata = mem[o_mem_addr];
      i_mem_ack = 1;
      @(negedge i_clk);
      i_mem_ack = 0;
    end
  end
  initial forever begin
    @(negedge i_clk);
    if (o_record_audio_ready && src_q.size() > 0) begin
      i_record_audio_data = src_q.pop_front();
      i_record_audio_valid = 1;
      @(negedge i_clk);
      i_record_audio_valid = 0;
    end
  end
  initial forever begin
    @(negedge i_clk);
    if (o_play_audio_valid) begin
      hold_d = o_play_audio_data;
      repeat (snk_dly - 1) @(negedge i_clk);
      if (o_play_audio_valid) begin
        chk("play_hold", o_play_audio_data, hold_d);
        i_play_audio_ready = 1;
        @(negedge i_clk);
        i_play_audio_ready = 0;
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge i_clk);
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_rec_len", 32'(o_rec_len), 32'd0);
    chk("rst_ready", 32'(o_record_audio_ready), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_we_re", 32'({o_mem_we, o_mem_re, o_play_audio_valid}), 32'd0);
    i_rst = 0;
    @(negedge i_clk);
    pulse(1);
    repeat (8) @(negedge i_clk);
    chk("empty_play_state", 32'(o_state), 32'd0);
    chk("empty_play_re", 32'(o_mem_re), 32'd0);
    for (int i = 0; i < 4; i++) begin
      src_q.push_back(rd[i]);
      push("W", i, rd[i]);
    end
    pulse(0);
    drain(200, "rec4_writes");
    wait_st(3'd1, 20, "rec4_wait");
    pulse(3);
    chk("rec4_stop_state", 32'(o_state), 32'd0);
    chk("rec4_ready_low", 32'(o_record_audio_ready), 32'd0);
    chk("rec4_len", 32'(o_rec_len), 32'd4);
    for (int i = 0; i < 4; i++) begin
      push("R", i, 32'd0);
      push("P", 0, rd[i]);
    end
    pulse(1);
    wait_st(3'd0, 300, "play4_end");
    chk("play4_busy", 32'(o_busy), 32'd0);
    chk("play4_drain", 32'(exp_q.size()), 32'd0);
    chk("play4_len", 32'(o_rec_len), 32'd4);
    ack_dly = 5;
    src_q.push_back(32'hAAAA0001);
    push("W", 0, 32'hAAAA0001);
    pulse(0);
    wait_st(3'd2, 50, "stopwr_reach");
    pulse(3);
    chk("stopwr_we_held", 32'(o_mem_we), 32'd1);
    wait_st(3'd0, 50, "stopwr_idle");
    chk("stopwr_len", 32'(o_rec_len), 32'd1);
    chk("stopwr_we_low", 32'(o_mem_we), 32'd0);
    ack_dly = 2;
    for (int i = 0; i < 5; i++) begin
      src_q.push_back(32'hE0 + 32'(i));
      push("W", i, 32'hE0 + 32'(i));
    end
    pulse(0);
    drain(200, "rec5_writes");
    wait_st(3'd1, 20, "rec5_wait");
    pulse(3);
    chk("rec5_len", 32'(o_rec_len), 32'd5);
    for (int i = 0; i < 3; i++) begin
      push("R", i, 32'd0);
      push("P", 0, 32'hE0 + 32'(i));
    end
    snk_dly = 4;
    pulse(1);
    for (int i = 0; i < 100 && !(o_play_audio_valid && o_mem_addr == 3'd2); i++) @(negedge i_clk);
    chk("pause_at_addr2", 32'(o_mem_addr), 32'd2);
    pulse(2);
    chk("pause_holds_out", 32'(o_state), 32'd4);
    wait_st(3'd5, 20, "pause_enter");
    chk("pause_addr", 32'(o_mem_addr), 32'd3);
    repeat (6) @(negedge i_clk);
    chk("pause_stays", 32'(o_state), 32'd5);
    chk("pause_no_read", 32'(o_mem_re), 32'd0);
    for (int i = 3; i < 5; i++) begin
      push("R", i, 32'd0);
      push("P", 0, 32'hE0 + 32'(i));
    end
    pulse(2);
    chk("resume_state", 32'(o_state), 32'd3);
    chk("resume_addr", 32'(o_mem_addr), 32'd3);
    wait_st(3'd0, 200, "resume_end");
    chk("resume_drain", 32'(exp_q.size()), 32'd0);
    snk_dly = 2;
    i_rst = 1;
    repeat (2) @(negedge i_clk);
    i_rst = 0;
    chk("rst2_len", 32'(o_rec_len), 32'd0);
    for (int i = 0; i < 8; i++) begin
      src_q.push_back(32'hF000 + 32'(i));
      push("W", i, 32'hF000 + 32'(i));
    end
    pulse(0);
    wait_st(3'd0, 400, "full_idle");
    chk("full_len", 32'(o_rec_len), 32'd8);
    chk("full_drain", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 8; i++) begin
      push("R", i, 32'd0);
      push("P", 0, 32'hF000 + 32'(i));
    end
`ifdef LOOP_PLAY_EN
    push("R", 0, 32'd0);
    push("P", 0, 32'hF000);
    pulse(1);
    drain(400, "loop_wrap");
    pulse(3);
    wait_st(3'd0, 20, "loop_stop");
`else
    pulse(1);
    wait_st(3'd0, 400, "full_play_end");
`endif
    repeat (4) @(negedge i_clk);
    chk("full_play_drain", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
